nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
Multi-cycle wide adder built around the existing 4-bit ripple adder. It accepts two NIBBLES*4-bit operands plus a carry-in over a valid/ready handshake. It feeds one nibble per cycle into an `adder` instance and chains the carry through a register. It returns a (NIBBLES*4+1)-bit sum over a second valid/ready handshake, and sits between the operand source and the result consumer in the datapath.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high; clears all state
in_valid  input  1  operands and cin present
in_ready  output  1  block can accept operands
op_a  input  W  operand A
op_b  input  W  operand B
cin  input  1  carry-in for the least significant nibble
out_valid  output  1  sum is available
out_ready  input  1  consumer accepts sum
sum  output  W+1  result; MSB is the final carry-out

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, carry reg=0, operand and result regs=0.
- Outputs during reset: in_ready=0, out_valid=0, sum=0.
- FSM states: IDLE, RUN, DONE.
- in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE: on a clock edge with in_valid&&in_ready:
  - latch op_a and op_b into shift regs a_q and b_q
  - carry_q<=cin, cnt<=0, result_q<=0
  - state->RUN
  - Without in_valid, remain in IDLE.
- RUN: adder inputs are A=a_q[3:0], B=b_q[3:0], CI=carry_q (combinational). Each edge:
  - result_q nibble[cnt] <= S[3:0]
  - carry_q <= S[4]
  - a_q and b_q shift right 4 bits
  - cnt<=cnt+1
  - When cnt==NIBBLES-1, state->DONE instead of incrementing.
- DONE: sum={carry_q, result_q}, held stable while out_valid=1. On an edge with out_ready=1, state->IDLE. No other state changes in DONE.
- Latency: operands accepted at edge k -> out_valid=1 after edge k+NIBBLES. in_ready returns 1 the cycle after output handshake.
- Throughput: one operation per NIBBLES+2 cycles minimum. No overlap of operations.
- Arithmetic: unsigned modulo 2^(W+1). Carry out of each nibble propagates only through carry_q, never combinationally across nibbles.
- Boundary conditions:
  - in_valid asserted outside IDLE is ignored; operands are not sampled.
  - out_ready asserted outside DONE has no effect.
  - out_ready held low: DONE persists indefinitely, sum unchanged.
  - NIBBLES=1: RUN lasts exactly one cycle.
  - rst mid-RUN or mid-DONE: immediate return to IDLE, partial result discarded, out_valid drops asynchronously.
- cnt width: clog2(NIBBLES), minimum 1 bit.

Decomposition:
- Shared package holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - NIBBLE_W=4 constant
- One sub-module: the existing `adder` (4-bit A, B, CI -> 5-bit S), instantiated once. No new sub-module needed.

Test Plan:
- Basic add: NIBBLES=4, op_a=0x0003, op_b=0x0004, cin=0 -> after 4 RUN cycles out_valid=1, sum=0x00007.
- Full carry ripple: op_a=0xFFFF, op_b=0x0001, cin=0 -> sum=0x10000. Check carry_q=1 after each RUN edge.
- Per-nibble carry-in: op_a=0x7777, op_b=0x7777, cin=1 -> sum=0x0EEEF. Maximum case: 0xFFFF+0xFFFF, cin=1 -> sum=0x1FFFF.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> sum stable and in_ready=0 throughout. Pulse in_valid with new operands during this window -> ignored. After out_ready=1 for one edge, in_ready=1 next cycle.
- Async reset mid-op: assert rst between RUN edges 2 and 3 -> out_valid=0, in_ready=0 immediately. After release, in_ready=1 and the next op 0x0002+0x0005+1 -> sum=0x00008.
- NIBBLES=1 instance: op_a=0x9, op_b=0x9, cin=1 -> out_valid one edge after acceptance, sum=5'h13.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial wide adder.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must keep at least one bit even when only one nibble is processed.
  function automatic int cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle between the operand source and the result consumer.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;

  modport master (
    output in_valid, op_a, op_b, cin, out_ready,
    input  in_ready, out_valid, sum
  );

  modport slave (
    input  in_valid, op_a, op_b, cin, out_ready,
    output in_ready, out_valid, sum
  );

endinterface

// File: rtl/nibble_serial_adder_adder.sv
// The existing 4-bit ripple adder slice: S = A + B + CI, S[4] is carry-out.
module adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CI,
  output logic [4:0] S
);

  assign S = {1'b0, A} + {1'b0, B} + {4'b0000, CI};

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that pushes one nibble per cycle through a single 4-bit adder,
// carrying between nibbles only through a register.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_adder_if.slave  bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_result;
  logic             w_load;
  logic             w_step;
  logic [4:0]       w_s;

  adder u_adder (
    .A  (r_a[NIBBLE_W-1:0]),
    .B  (r_b[NIBBLE_W-1:0]),
    .CI (r_carry),
    .S  (w_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand shift registers, carry chain register, nibble counter and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_load) begin
      r_a      <= bus.op_a;
      r_b      <= bus.op_b;
      r_carry  <= bus.cin;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_step) begin
      r_result[r_cnt*NIBBLE_W +: NIBBLE_W] <= w_s[3:0];
      r_carry <= w_s[4];
      r_a     <= r_a >> NIBBLE_W;
      r_b     <= r_b >> NIBBLE_W;
      if (r_cnt != CNT_LAST) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // in_ready is masked by rst so it reads low while reset is held, even though the state is IDLE.
  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out_valid = (r_state == DONE);
  assign bus.sum       = (r_state == DONE) ? {r_carry, r_result} : '0;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for the nibble-serial adder: a 4-nibble and a 1-nibble instance.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.NIBBLES(4)) bus4 ();
  nibble_serial_adder_if #(.NIBBLES(1)) bus1 ();

  nibble_serial_adder #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  nibble_serial_adder #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One 4-nibble operation; hold = backpressure cycles, early = out_ready high during RUN.
  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic c,
                     input logic [16:0] exp, input int hold, input logic early);
    logic [4:0] s;
    logic       cy;
    @(negedge clk);
    check_eq("in_ready_idle", {31'd0, bus4.in_ready}, 32'd1);
    bus4.in_valid = 1'b1;
    bus4.op_a     = a;
    bus4.op_b     = b;
    bus4.cin      = c;
    @(posedge clk);
    #1;
    bus4.in_valid  = 1'b0;
    bus4.op_a      = 16'hDEAD;
    bus4.op_b      = 16'hBEEF;
    bus4.cin       = ~c;
    bus4.out_ready = early;
    cy = c;
    for (int i = 0; i < 4; i++) begin
      s  = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'd0, cy};
      cy = s[4];
      check_eq("in_ready_run", {31'd0, bus4.in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check_eq("carry_q", {31'd0, dut4.r_carry}, {31'd0, cy});
      if (i < 3) check_eq("out_valid_run", {31'd0, bus4.out_valid}, 32'd0);
    end
    bus4.out_ready = 1'b0;
    check_eq("out_valid_done", {31'd0, bus4.out_valid}, 32'd1);
    check_eq("sum", {15'd0, bus4.sum}, {15'd0, exp});
    for (int h = 0; h < hold; h++) begin
      bus4.in_valid = (h == 2);
      bus4.op_a     = 16'h1111;
      bus4.op_b     = 16'h2222;
      @(posedge clk);
      #1;
      bus4.in_valid = 1'b0;
      check_eq("bp_sum", {15'd0, bus4.sum}, {15'd0, exp});
      check_eq("bp_in_ready", {31'd0, bus4.in_ready}, 32'd0);
      check_eq("bp_out_valid", {31'd0, bus4.out_valid}, 32'd1);
    end
    bus4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus4.out_ready = 1'b0;
    check_eq("in_ready_after", {31'd0, bus4.in_ready}, 32'd1);
    check_eq("out_valid_after", {31'd0, bus4.out_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus4.in_valid = 1'b0; bus4.op_a = 16'h0; bus4.op_b = 16'h0; bus4.cin = 1'b0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.op_a = 4'h0;  bus1.op_b = 4'h0;  bus1.cin = 1'b0; bus1.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'd0, bus4.in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
    check_eq("rst_sum", {15'd0, bus4.sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    op4(16'h0003, 16'h0004, 1'b0, 17'h00007, 0, 1'b0);
    op4(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 0, 1'b1);
    op4(16'h7777, 16'h7777, 1'b1, 17'h0EEEF, 0, 1'b0);
    op4(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 0, 1'b0);
    op4(16'h1234, 16'h4321, 1'b0, 17'h05555, 10, 1'b0);

    // Reset between the second and third RUN edges.
    @(negedge clk);
    bus4.in_valid = 1'b1;
    bus4.op_a     = 16'hABCD;
    bus4.op_b     = 16'h1111;
    bus4.cin      = 1'b0;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
    check_eq("arst_in_ready", {31'd0, bus4.in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("arst_release_ready", {31'd0, bus4.in_ready}, 32'd1);
    op4(16'h0002, 16'h0005, 1'b1, 17'h00008, 0, 1'b0);

    // Single-nibble instance: RUN lasts one cycle.
    @(negedge clk);
    check_eq("n1_in_ready", {31'd0, bus1.in_ready}, 32'd1);
    bus1.in_valid = 1'b1;
    bus1.op_a     = 4'h9;
    bus1.op_b     = 4'h9;
    bus1.cin      = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    check_eq("n1_out_valid_run", {31'd0, bus1.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("n1_out_valid", {31'd0, bus1.out_valid}, 32'd1);
    check_eq("n1_sum", {27'd0, bus1.sum}, 32'h13);
    bus1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus1.out_ready = 1'b0;
    check_eq("n1_in_ready_after", {31'd0, bus1.in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
